// File: rtl/vga_axil_pkg.sv
// Shared AXI-Lite types, response codes and the VGA CSR register map.
// Imported by the CSR top and by the reusable write-join block.
package vga_axil_pkg;

    typedef logic [31:0] axil_addr_t;
    typedef logic [31:0] axil_data_t;
    typedef logic [1:0]  axil_resp_t;
    typedef logic [3:0]  axil_strb_t;

    localparam axil_resp_t AXIL_RESP_OKAY   = 2'b00;
    localparam axil_resp_t AXIL_RESP_SLVERR = 2'b10;

    localparam logic [3:0] VGA_CSR_CTRL   = 4'h0;
    localparam logic [3:0] VGA_CSR_COLOR  = 4'h4;
    localparam logic [3:0] VGA_CSR_STATUS = 4'h8;
    localparam logic [3:0] VGA_CSR_IRQ    = 4'hC;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // Only the first 16 bytes decode; anything above is out of map.
    function automatic logic addr_in_map(input axil_addr_t addr);
        return addr[31:4] == '0;
    endfunction

    function automatic logic [3:0] word_offset(input axil_addr_t addr);
        return {addr[3:2], 2'b00};
    endfunction

endpackage

// File: rtl/vga_axil_wr_join.sv
// Joins independently arriving AXI-Lite AW and W beats into one write strobe
// and owns the B response. Every channel uses valid/ready: a beat transfers on
// the rising edge where both are high; a held response stays stable until taken.
module vga_axil_wr_join
    import vga_axil_pkg::*;
(
    input  logic       clk,
    input  logic       arst_n,
    input  axil_addr_t awaddr,
    input  logic       awvalid,
    output logic       awready,
    input  axil_data_t wdata,
    input  axil_strb_t wstrb,
    input  logic       wvalid,
    output logic       wready,
    output axil_resp_t bresp,
    output logic       bvalid,
    input  logic       bready,
    output logic       wr_en_o,
    output axil_addr_t wr_addr_o,
    output axil_data_t wr_data_o,
    output axil_strb_t wr_strb_o,
    input  axil_resp_t wr_resp_i
);

    logic       aw_held_q, aw_held_d;
    axil_addr_t aw_addr_q, aw_addr_d;
    logic       w_held_q, w_held_d;
    axil_data_t w_data_q, w_data_d;
    axil_strb_t w_strb_q, w_strb_d;
    logic       bvalid_q, bvalid_d;
    axil_resp_t bresp_q, bresp_d;
    logic       aw_hs, w_hs;

    assign awready = !aw_held_q && !bvalid_q;
    assign wready  = !w_held_q && !bvalid_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

    always_comb begin
        aw_hs     = awvalid && awready;
        w_hs      = wvalid && wready;
        // A beat arriving this cycle counts as held, giving one-cycle latency.
        wr_addr_o = aw_held_q ? aw_addr_q : awaddr;
        wr_data_o = w_held_q ? w_data_q : wdata;
        wr_strb_o = w_held_q ? w_strb_q : wstrb;
        wr_en_o   = (aw_held_q || aw_hs) && (w_held_q || w_hs);

        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q && !bready;
        bresp_d   = bresp_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (wr_en_o) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_resp_i;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXIL_RESP_OKAY;
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

endmodule

// File: rtl/vga_axil_csr.sv
// AXI-Lite CSR block for the VGA path: enable/colour control, frame counter,
// sticky frame-done flag with W1C clear and a registered level interrupt.
module vga_axil_csr
    import vga_axil_pkg::*;
#(
    parameter int FRAME_CNT_W = 16,
    parameter int COLOR_W     = 12
) (
    input  logic               clk,
    input  logic               arst_n,
    input  axil_addr_t         araddr,
    input  logic               arvalid,
    output logic               arready,
    output axil_data_t         rdata,
    output axil_resp_t         rresp,
    output logic               rvalid,
    input  logic               rready,
    input  axil_addr_t         awaddr,
    input  logic               awvalid,
    output logic               awready,
    input  axil_data_t         wdata,
    input  axil_strb_t         wstrb,
    input  logic               wvalid,
    output logic               wready,
    output axil_resp_t         bresp,
    output logic               bvalid,
    input  logic               bready,
    input  logic               frame_start_i,
    input  logic               vblank_i,
    output logic               enable_o,
    output logic [COLOR_W-1:0] color_o,
    output logic               irq_o
);

    logic                   wr_en, wr_ok;
    axil_addr_t             wr_addr;
    axil_data_t             wr_data;
    axil_strb_t             wr_strb;
    axil_resp_t             wr_resp;
    logic [3:0]             wr_off, rd_off;

    logic [1:0]             ctrl_q, ctrl_d;
    logic [COLOR_W-1:0]     color_q, color_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   frame_done_q, frame_done_d;
    logic                   vblank_q;
    logic                   irq_q, irq_d;
    logic                   rvalid_q, rvalid_d;
    axil_data_t             rdata_q, rdata_d, rd_word;
    axil_resp_t             rresp_q, rresp_d;
    logic                   ar_hs, rd_ok;
    logic                   unused_bits;

    vga_axil_wr_join u_wr_join (
        .clk       (clk),
        .arst_n    (arst_n),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .wr_resp_i (wr_resp)
    );

    assign unused_bits = ^{wr_addr[1:0], wr_data, wr_strb, araddr[1:0]};

    assign enable_o = ctrl_q[CTRL_ENABLE_BIT];
    assign color_o  = color_q;
    assign irq_o    = irq_q;
    assign arready  = !rvalid_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;

    always_comb begin
        wr_off       = word_offset(wr_addr);
        wr_ok        = addr_in_map(wr_addr) && (wr_off != VGA_CSR_STATUS);
        wr_resp      = wr_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
        ctrl_d       = ctrl_q;
        color_d      = color_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = frame_done_q;

        if (wr_en && wr_ok) begin
            case (wr_off)
                VGA_CSR_CTRL:  if (wr_strb[0]) ctrl_d = wr_data[1:0];
                VGA_CSR_COLOR: begin
                    for (int i = 0; i < COLOR_W; i++) begin
                        if (wr_strb[i / 8]) color_d[i] = wr_data[i];
                    end
                end
                VGA_CSR_IRQ:   if (wr_strb[0] && wr_data[0]) frame_done_d = 1'b0;
                default: ;
            endcase
        end
        // Applied after the W1C so a coincident frame start keeps the flag set.
        if (frame_start_i) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
        end
        irq_d = frame_done_q && ctrl_q[CTRL_IRQ_EN_BIT];
    end

    always_comb begin
        ar_hs   = arvalid && arready;
        rd_off  = word_offset(araddr);
        rd_ok   = addr_in_map(araddr);
        rd_word = '0;
        case (rd_off)
            VGA_CSR_CTRL:   rd_word[1:0] = ctrl_q;
            VGA_CSR_COLOR:  rd_word[COLOR_W-1:0] = color_q;
            VGA_CSR_STATUS: begin
                rd_word[0]                = vblank_q;
                rd_word[16 +: FRAME_CNT_W] = frame_cnt_q;
            end
            VGA_CSR_IRQ:    rd_word[0] = frame_done_q;
            default: ;
        endcase
        rvalid_d = rvalid_q && !rready;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_ok ? rd_word : '0;
            rresp_d  = rd_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ctrl_q       <= '0;
            color_q      <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            vblank_q     <= 1'b0;
            irq_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= AXIL_RESP_OKAY;
        end else begin
            ctrl_q       <= ctrl_d;
            color_q      <= color_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            vblank_q     <= vblank_i;
            irq_q        <= irq_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
        end
    end

endmodule

// File: tb/tb_vga_axil_csr.sv
// Directed bench for vga_axil_csr: a register-access vector table plus
// hand-written sequences for handshake timing, interrupts and counter wrap.
module tb_vga_axil_csr;
    import vga_axil_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    axil_addr_t  araddr = '0, awaddr = '0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    axil_data_t  wdata = '0;
    axil_strb_t  wstrb = '0;
    logic        frame_start_i = 1'b0, vblank_i = 1'b0;
    logic        arready, rvalid, awready, wready, bvalid, enable_o, irq_o;
    axil_data_t  rdata;
    axil_resp_t  rresp, bresp;
    logic [11:0] color_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        do_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;
    vec_t vecs[10];

    vga_axil_csr #(.FRAME_CNT_W(16), .COLOR_W(12)) dut (
        .clk(clk), .arst_n(arst_n),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .frame_start_i(frame_start_i), .vblank_i(vblank_i),
        .enable_o(enable_o), .color_o(color_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 100) begin step(); n++; end
        if (n >= 100) timeout("wr_ready");
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 100) begin step(); n++; end
        if (n >= 100) timeout("wr_bvalid");
        resp = bresp;
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin step(); n++; end
        if (n >= 100) timeout("rd_arready");
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 100) begin step(); n++; end
        if (n >= 100) timeout("rd_rvalid");
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start_i = 1'b1;
        step();
        frame_start_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs, bs;

        vecs[0] = '{1'b1, 32'h04, 32'hFFFF_F123, 4'h0, AXIL_RESP_OKAY,   32'h0000_0ABC, AXIL_RESP_OKAY};
        vecs[1] = '{1'b1, 32'h04, 32'h0000_0F56, 4'h1, AXIL_RESP_OKAY,   32'h0000_0A56, AXIL_RESP_OKAY};
        vecs[2] = '{1'b1, 32'h05, 32'h0000_0300, 4'h2, AXIL_RESP_OKAY,   32'h0000_0356, AXIL_RESP_OKAY};
        vecs[3] = '{1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, AXIL_RESP_OKAY,   32'h0000_0003, AXIL_RESP_OKAY};
        vecs[4] = '{1'b1, 32'h00, 32'h0000_0001, 4'h1, AXIL_RESP_OKAY,   32'h0000_0001, AXIL_RESP_OKAY};
        vecs[5] = '{1'b1, 32'h08, 32'h1234_5678, 4'hF, AXIL_RESP_SLVERR, 32'h0000_0000, AXIL_RESP_OKAY};
        vecs[6] = '{1'b1, 32'h10, 32'h0000_0FFF, 4'hF, AXIL_RESP_SLVERR, 32'h0000_0000, AXIL_RESP_SLVERR};
        vecs[7] = '{1'b1, 32'h0C, 32'h0000_0000, 4'hF, AXIL_RESP_OKAY,   32'h0000_0000, AXIL_RESP_OKAY};
        vecs[8] = '{1'b0, 32'h1C, 32'h0,         4'h0, AXIL_RESP_OKAY,   32'h0000_0000, AXIL_RESP_SLVERR};
        vecs[9] = '{1'b0, 32'h07, 32'h0,         4'h0, AXIL_RESP_OKAY,   32'h0000_0356, AXIL_RESP_OKAY};

        // Clock/reset
        repeat (3) @(posedge clk);
        #3 arst_n = 1'b1;
        step();
        check("rst_enable", enable_o, 0);
        check("rst_color", color_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_readies", {awready, wready, arready}, 3'b111);
        check("rst_valids", {rvalid, bvalid}, 2'b00);

        // AW at cycle 0, W at cycle 3, bvalid at cycle 4
        awaddr = 32'h4; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("aw_only_awready", awready, 0);
        check("aw_only_bvalid", bvalid, 0);
        step();
        step();
        wdata = 32'h0000_0ABC; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("split_bvalid", bvalid, 1);
        check("split_bresp", bresp, AXIL_RESP_OKAY);
        check("split_color", color_o, 12'hABC);
        bready = 1'b1; step(); bready = 1'b0;
        axi_read(32'h4, rd, rs);
        check("split_rdata", rd, 32'h0000_0ABC);
        check("split_rresp", rs, AXIL_RESP_OKAY);

        // Register access table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) begin
                axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, bs);
                check($sformatf("vec%0d_bresp", i), bs, vecs[i].exp_bresp);
            end
            axi_read(vecs[i].addr, rd, rs);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rresp", i), rs, vecs[i].exp_rresp);
        end

        // Frame counting and interrupt
        axi_write(32'h0, 32'h3, 4'hF, bs);
        check("ctrl_enable", enable_o, 1);
        repeat (3) pulse_frame();
        step();
        axi_read(32'h8, rd, rs);
        check("status_cnt3", rd, 32'h0003_0000);
        axi_read(32'hC, rd, rs);
        check("irq_reg_set", rd, 1);
        check("irq_o_set", irq_o, 1);
        awaddr = 32'hC; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check("w1c_bvalid", bvalid, 1);
        check("irq_o_lag", irq_o, 1);
        step();
        check("irq_o_cleared", irq_o, 0);
        bready = 1'b1; step(); bready = 1'b0;

        // W1C coincident with frame start: set wins
        pulse_frame();
        awaddr = 32'hC; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        frame_start_i = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; frame_start_i = 1'b0;
        bready = 1'b1; step(); bready = 1'b0;
        axi_read(32'hC, rd, rs);
        check("race_done_kept", rd, 1);
        axi_read(32'h8, rd, rs);
        check("race_cnt5", rd, 32'h0005_0000);
        check("race_irq_o", irq_o, 1);
        axi_write(32'hC, 32'h1, 4'h1, bs);
        step();
        check("irq_o_after_clear", irq_o, 0);

        // vblank sampling
        vblank_i = 1'b1;
        step(); step();
        axi_read(32'h8, rd, rs);
        check("status_vblank", rd, 32'h0005_0001);
        vblank_i = 1'b0;

        // B response held while bready is low
        awaddr = 32'h4; wdata = 32'h0000_0DEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bhold%0d_state", k), {bvalid, awready, wready}, 3'b100);
            step();
        end
        check("bhold_color", color_o, 12'hDEF);
        bready = 1'b1; step(); bready = 1'b0;
        check("bhold_released", {bvalid, awready, wready}, 3'b011);

        // Counter wrap: 5 -> 0xFFFF -> 0
        frame_start_i = 1'b1;
        repeat (65530) @(posedge clk);
        #1 frame_start_i = 1'b0;
        axi_read(32'h8, rd, rs);
        check("cnt_ffff", rd, 32'hFFFF_0000);
        pulse_frame();
        axi_read(32'h8, rd, rs);
        check("cnt_wrap", rd, 32'h0000_0000);

        // Reset mid-transaction discards a captured AW
        awaddr = 32'h4; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        arst_n = 1'b0;
        #2;
        check("midrst_state", {awready, bvalid, enable_o, irq_o}, 4'b1000);
        check("midrst_color", color_o, 0);
        step();
        arst_n = 1'b1;
        step();
        wdata = 32'h0000_0111; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        step();
        check("midrst_no_write", {bvalid, wready}, 2'b00);
        check("midrst_color_kept", color_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
